// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-period pulse train whose high time is a clamped
// command sampled only at period boundaries.
module servo_pwm_gen #(
  parameter int PERIOD    = 2_000_000,
  parameter int MIN_WIDTH = 50_000,
  parameter int MAX_WIDTH = 250_000,
  parameter int CNT_BITS  = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [19:0] width_in,
  output logic        pwm_out,
  output logic        period_start,
  output logic [19:0] width_active,
  output logic        clamped,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int                  CW    = (CNT_BITS > 20) ? CNT_BITS : 20;
  localparam logic [CNT_BITS-1:0] LAST  = CNT_BITS'(PERIOD - 1);
  localparam logic [19:0]         MIN_W = 20'(MIN_WIDTH);
  localparam logic [19:0]         MAX_W = 20'(MAX_WIDTH);

  // Returns {clamped_flag, clamped_width}; zero passes through as "no pulse".
  function automatic logic [20:0] clamp_width(input logic [19:0] w);
    logic [20:0] r;
    if (w == 20'd0) begin
      r = {1'b0, 20'd0};
    end else if (w < MIN_W) begin
      r = {1'b1, MIN_W};
    end else if (w > MAX_W) begin
      r = {1'b1, MAX_W};
    end else begin
      r = {1'b0, w};
    end
    return r;
  endfunction

  state_t              state_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic [20:0]         load_s;
  logic [CNT_BITS-1:0] cnt_inc_s;
  logic                at_last_s;
  logic                do_load_s;
  logic                pulse_next_s;

  // Next-period command, counter step and the load decision.
  always_comb begin
    load_s       = clamp_width(width_in);
    cnt_inc_s    = cnt_r + CNT_BITS'(1);
    at_last_s    = (cnt_r == LAST);
    pulse_next_s = (CW'(cnt_inc_s) < CW'(width_active));
    if (state_r == IDLE) begin
      do_load_s = enable;
    end else begin
      do_load_s = enable && at_last_s;
    end
  end

  // State machine with all outputs registered; a load starts a fresh period at cnt 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      width_active <= 20'd0;
      clamped      <= 1'b0;
      busy         <= 1'b0;
    end else if (do_load_s) begin
      state_r      <= RUN;
      cnt_r        <= '0;
      width_active <= load_s[19:0];
      clamped      <= load_s[20];
      pwm_out      <= (load_s[19:0] != 20'd0);
      period_start <= 1'b1;
      busy         <= 1'b1;
    end else begin
      case (state_r)
        RUN, DRAIN: begin
          if (at_last_s) begin
            // Period finished with enable low: stop without reloading.
            state_r      <= IDLE;
            cnt_r        <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
          end else begin
            state_r      <= enable ? RUN : DRAIN;
            cnt_r        <= cnt_inc_s;
            pwm_out      <= pulse_next_s;
            period_start <= 1'b0;
            busy         <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= '0;
          pwm_out      <= 1'b0;
          period_start <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: period-position reference model,
// per-cycle comparison, directed scenarios and randomized command/enable/reset traffic.
module tb_servo_pwm_gen;

  localparam int P    = 100;
  localparam int MINW = 5;
  localparam int MAXW = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [19:0] width_in = 20'd0;
  logic        pwm_out;
  logic        period_start;
  logic [19:0] width_active;
  logic        clamped;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  servo_pwm_gen #(.PERIOD(P), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .width_in(width_in),
    .pwm_out(pwm_out), .period_start(period_start), .width_active(width_active),
    .clamped(clamped), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: idle flag, position inside the current period, and the width loaded at its start.
  bit m_idle    = 1'b1;
  int m_pos     = 0;
  int m_width   = 0;
  bit m_clamped = 1'b0;

  function automatic int model_clamp(input int w);
    if (w == 0) return 0;
    else if (w < MINW) return MINW;
    else if (w > MAXW) return MAXW;
    else return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1; m_pos <= 0; m_width <= 0; m_clamped <= 1'b0;
    end else if (m_idle || m_pos == P - 1) begin
      if (enable) begin
        m_idle    <= 1'b0;
        m_pos     <= 0;
        m_width   <= model_clamp(int'(width_in));
        m_clamped <= (model_clamp(int'(width_in)) != int'(width_in));
      end else begin
        m_idle <= 1'b1;
        m_pos  <= 0;
      end
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on the inactive clock edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("pwm_out",      32'(pwm_out),      32'(!m_idle && m_pos < m_width));
      check("period_start", 32'(period_start), 32'(!m_idle && m_pos == 0));
      check("width_active", 32'(width_active), 32'(m_width));
      check("clamped",      32'(clamped),      32'(m_clamped));
      check("busy",         32'(busy),         32'(!m_idle));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [19:0] rand_width();
    case ($urandom_range(3, 0))
      0: return 20'd0;
      1: return 20'($urandom_range(MINW - 1, 1));
      2: return 20'($urandom_range(MAXW, MINW));
      default: return 20'($urandom_range(1048575, MAXW + 1));
    endcase
  endfunction

  initial begin
    wait_cycles(3);
    chk_on = 1'b1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_width", 32'(width_active), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Nominal 12-cycle pulses.
    rst = 1'b0; width_in = 20'd12; enable = 1'b1;
    wait_cycles(1);
    check("first_ps", 32'(period_start), 32'd1);
    check("first_pwm", 32'(pwm_out), 32'd1);
    check("first_width", 32'(width_active), 32'd12);
    wait_cycles(11);
    check("pwm_last_high", 32'(pwm_out), 32'd1);
    wait_cycles(1);
    check("pwm_first_low", 32'(pwm_out), 32'd0);
    wait_cycles(88);
    check("second_ps", 32'(period_start), 32'd1);

    // Mid-period command change is deferred to the next load.
    wait_cycles(4);
    width_in = 20'd18;
    wait_cycles(96);
    check("deferred_width", 32'(width_active), 32'd18);

    // Clamping below MIN and above MAX.
    width_in = 20'd3;
    wait_cycles(100);
    check("clamp_min_w", 32'(width_active), 32'd5);
    check("clamp_min_f", 32'(clamped), 32'd1);
    width_in = 20'd30;
    wait_cycles(100);
    check("clamp_max_w", 32'(width_active), 32'd20);
    check("clamp_max_f", 32'(clamped), 32'd1);

    // Drain to idle after enable drops mid-period.
    wait_cycles(50);
    enable = 1'b0;
    wait_cycles(49);
    check("drain_busy", 32'(busy), 32'd1);
    wait_cycles(1);
    check("idle_busy", 32'(busy), 32'd0);
    wait_cycles(20);
    check("idle_ps", 32'(period_start), 32'd0);

    // Drop and re-enable within one period: no gap.
    enable = 1'b1;
    wait_cycles(1);
    wait_cycles(50);
    enable = 1'b0;
    wait_cycles(20);
    enable = 1'b1;
    wait_cycles(30);
    check("reenable_ps", 32'(period_start), 32'd1);

    // Reset in the middle of a pulse.
    width_in = 20'd12;
    wait_cycles(100);
    wait_cycles(6);
    rst = 1'b1; enable = 1'b0;
    wait_cycles(1);
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    check("midrst_width", 32'(width_active), 32'd0);
    rst = 1'b0;
    wait_cycles(10);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Zero command: periods continue, no pulse.
    width_in = 20'd0; enable = 1'b1;
    wait_cycles(300);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) width_in = rand_width();
      if ($urandom_range(59, 0) == 0) enable = ~enable;
      rst = ($urandom_range(499, 0) == 0);
      wait_cycles(1);
    end
    rst = 1'b0;
    wait_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
